// File: rtl/lsu_mem_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types and constants for the LSU memory adapter: access
//             size encoding, adapter FSM states, word size and lane helper.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Right-aligned byte-lane mask for an access size; reserved size 3 acts as a word.
    function automatic logic [3:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_adapter_if
//  Brief    : Request/response and memory-side bundle of the LSU adapter.
//             slave  = adapter view, master = LSU core / memory view.
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_adapter_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_valid;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_raddr;
    logic [XLEN-1:0]   mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_adapter_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Brief    : Combinational load alignment: shifts the {hi,lo} word pair down
//             by the byte offset, truncates to the access size and sign- or
//             zero-extends.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data64,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_en,
    output logic [31:0] rdata
);

    logic [63:0] w_shift;
    logic [31:0] w_word;
    logic        w_unused_hi;

    assign w_shift     = data64 >> {off, 3'b000};
    assign w_word      = w_shift[31:0];
    // Only the low word of the shifted pair can ever hold requested bytes.
    assign w_unused_hi = ^w_shift[63:32];

    // Truncate to the access size and extend.
    always_comb begin
        rdata = w_word;
        case (size)
            SZ_B:    rdata = {{24{sign_en & w_word[7]}},  w_word[7:0]};
            SZ_H:    rdata = {{16{sign_en & w_word[15]}}, w_word[15:0]};
            default: rdata = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_adapter
//  Brief    : Splits one RV32 byte/half/word load/store at any alignment into
//             one or two word-aligned memory beats and returns a single
//             response with extended load data. mem_valid pulses exactly one
//             cycle per beat.
//  Options  : LSU_MISALIGN_TRAP_EN - word-crossing accesses issue no beat and
//             respond next cycle with resp_err=1.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MASK_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    lsu_mem_adapter_if.slave bus
);

    lsu_state_e        r_state;
    logic              r_wen;
    logic              r_signed;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic [2*XLEN-1:0] r_data64;
    logic [7:0]        r_mask8;
    logic [XLEN-1:0]   r_lo;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_valid;
    logic              r_mem_wen;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [MASK_W-1:0] r_mem_wmask;

    logic [1:0]        w_off;
    logic [7:0]        w_mask8;
    logic [2*XLEN-1:0] w_data64;
    logic [XLEN-1:0]   w_word_addr;
    logic              w_trap;
    logic [2*XLEN-1:0] w_align_in;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_resp_data;

    // Request decode: lane mask and lane-shifted data across a two-word window.
    assign w_off       = bus.req_addr[1:0];
    assign w_mask8     = {4'b0000, size_lanes(bus.req_size)} << w_off;
    assign w_data64    = {{XLEN{1'b0}}, bus.req_wdata} << {w_off, 3'b000};
    assign w_word_addr = {bus.req_addr[XLEN-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = |w_mask8[7:4];
`else
    assign w_trap = 1'b0;
`endif

    // Response data is registered on the edge that ends the last beat, so the
    // final word comes straight from mem_rdata and the earlier one from r_lo.
    assign w_align_in  = (r_state == BEAT1) ? {bus.mem_rdata, r_lo}
                                            : {{XLEN{1'b0}}, bus.mem_rdata};
    assign w_resp_data = r_wen ? '0 : w_load_data;

    lsu_load_align u_load_align (
        .data64  (w_align_in),
        .off     (r_off),
        .size    (r_size),
        .sign_en (r_signed),
        .rdata   (w_load_data)
    );

    // Adapter FSM with registered request, memory and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wen        <= 1'b0;
            r_signed     <= 1'b0;
            r_off        <= 2'd0;
            r_size       <= 2'd0;
            r_data64     <= '0;
            r_mask8      <= '0;
            r_lo         <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= bus.req_wen;
                        r_signed    <= bus.req_signed;
                        r_off       <= w_off;
                        r_size      <= bus.req_size;
                        r_data64    <= w_data64;
                        r_mask8     <= w_mask8;
                        if (w_trap) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= BEAT0;
                            r_mem_valid <= 1'b1;
                            r_mem_wen   <= bus.req_wen;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= w_data64[XLEN-1:0];
                            r_mem_wmask <= {{(MASK_W-4){1'b0}}, w_mask8[3:0]};
                        end
                    end
                end
                BEAT0: begin
                    r_lo <= bus.mem_rdata;
                    if (|r_mask8[7:4]) begin
                        r_state     <= BEAT1;
                        r_mem_addr  <= r_mem_addr + XLEN'(WORD_BYTES);
                        r_mem_wdata <= r_data64[2*XLEN-1:XLEN];
                        r_mem_wmask <= {{(MASK_W-4){1'b0}}, r_mask8[7:4]};
                    end else begin
                        r_state      <= RESP;
                        r_mem_valid  <= 1'b0;
                        r_mem_wen    <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_mem_wmask  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_data;
                    end
                end
                BEAT1: begin
                    r_state      <= RESP;
                    r_mem_valid  <= 1'b0;
                    r_mem_wen    <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= '0;
                    r_mem_wmask  <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_resp_data;
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_wen    = r_mem_wen;
    assign bus.mem_raddr  = r_mem_addr;
    assign bus.mem_waddr  = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wmask  = r_mem_wmask;

endmodule
`default_nettype wire

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store adapter directly upstream of the DPI memory controller (MemContrl).
- Turns one RV32 load/store request (byte/half/word, any alignment) into one or two word-aligned memory beats: word address, byte-lane write mask and lane-shifted write data.
- Assembles load data from the returned word(s) and sign- or zero-extends it; returns exactly one response per request.
- Guarantees mem_valid is high for exactly one cycle per beat, so the combinational DPI write fires once per beat.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MASK_W, 8, width of mem_wmask; only bits [3:0] are used, bits [7:4] are always 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  adapter can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- req_signed  in  1  load sign-extend enable
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misalign error (see Optional Feature)
- mem_valid  out  1  to MemContrl valid
- mem_wen  out  1  to MemContrl wen
- mem_raddr  out  32  word-aligned read address
- mem_waddr  out  32  word-aligned write address (equal to mem_raddr)
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  8  byte-lane mask
- mem_rdata  in  32  combinational read data from MemContrl

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_valid=0; mem_wen=0; all mem address/data/mask outputs 0.
- IDLE:
  - req_ready=1. On req_valid, latch the request and compute: off=addr[1:0]; nbytes=1/2/4.
  - Mask: mask8 = ((1<<nbytes)-1) << off.
  - Data: data64 = {32'b0, wdata} << (8*off).
  - Next state is BEAT0.
- BEAT0:
  - Drive mem_valid=1, mem_wen=latched wen, mem_raddr=mem_waddr={addr[31:2],2'b00}, mem_wdata=data64[31:0], mem_wmask={4'b0, mask8[3:0]}.
  - Capture mem_rdata into lo.
  - If mask8[7:4]!=0 (access crosses a word boundary), go to BEAT1; otherwise go to RESP.
- BEAT1:
  - Drive address = word address + 4, wrapping modulo 2^32. Drive mem_wdata=data64[63:32] and mem_wmask={4'b0, mask8[7:4]}.
  - Capture mem_rdata into hi. Go to RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - Load: resp_rdata = ({hi,lo} >> 8*off), truncated to nbytes and sign-extended if req_signed, else zero-extended.
  - Store: resp_rdata=0.
  - Go to IDLE.
- req_ready is 0 in every state except IDLE; requests offered then are ignored (not queued).
- Latency from acceptance (cycle N): non-crossing access gives resp_valid at N+2; crossing access gives N+3.
- Throughput: at most one request per 3 cycles (non-crossing) or 4 cycles (crossing).
- mem_valid is 0 in IDLE and RESP, never high two consecutive cycles for the same beat.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. A beat already issued is not undone (a store's first beat may remain written). No response is produced for the aborted request.
- resp_valid has no backpressure; the consumer must take it in that cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any crossing access (mask8[7:4]!=0) issues no memory beat. Path is IDLE -> RESP with resp_err=1 and resp_rdata=0; latency N+1.
- Undefined: crossing accesses are split into two beats as above, and resp_err is tied to 0.

Decomposition:
- Shared package lsu_pkg holds:
  - enum lsu_size_e {SZ_B, SZ_H, SZ_W}
  - enum lsu_state_e {IDLE, BEAT0, BEAT1, RESP}
  - constant WORD_BYTES=4
- Sub-module lsu_load_align: purely combinational {hi,lo}, off, size, signed -> extended rdata. Instantiated once.

Test Plan:
- Aligned word store: addr 0x80000010, wdata 0xDEADBEEF, size 2 -> one beat, waddr 0x80000010, wmask 0x0F, wdata 0xDEADBEEF; resp_valid at N+2.
- Signed byte load: mem word 0x80000000 = 0x8899AABB, addr 0x80000002, size 0, signed -> raddr 0x80000000, resp_rdata 0xFFFFFF99. Same load unsigned -> 0x00000099.
- Crossing half store: addr 0x80000003, wdata 0x1234 ->
  - beat0: waddr 0x80000000, wmask 0x08, wdata[31:24]=0x34.
  - beat1: waddr 0x80000004, wmask 0x01, wdata[7:0]=0x12.
  - resp at N+3.
- Crossing word load at wrap: addr 0xFFFFFFFE, size 2, mem[0xFFFFFFFC]=0xAABB0000, mem[0x0]=0x0000CCDD -> beat1 raddr 0x00000000, resp_rdata 0xCCDDAABB.
- Reset mid-flight: assert reset during BEAT1 of a crossing store -> next cycle mem_valid=0, req_ready=1, no resp_valid. A new request is then served normally.
- With LSU_MISALIGN_TRAP_EN: crossing load at 0x80000006 size 2 -> mem_valid never asserted; resp_valid=1, resp_err=1, resp_rdata=0 at N+1.
